// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: fetch FSM encoding and parameter defaults.
package instr_fetch_unit_pkg;
  localparam int unsigned PC_W_DEF     = 8;
  localparam int unsigned DEPTH_DEF    = 2;
  localparam int unsigned RESET_PC_DEF = 0;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_FULL = 2'd2,
    F_DROP = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Prefetch FIFO holding {pc, opcode} pairs; head is zero when empty so downstream never sees stale data.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           wdata_i,
  output logic [W-1:0]           rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] cnt_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rd_q];
  assign cnt_o   = cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, requests one opcode byte per instruction and prefetches into a FIFO.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned PC_W     = PC_W_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic            in_clka,
  input  logic            in_restart_n,
  output logic [PC_W-1:0] out_mem_addr,
  output logic            out_mem_req,
  input  logic            in_mem_ack,
  input  logic [7:0]      in_mem_data,
  output logic [7:0]      out_instruction,
  output logic [PC_W-1:0] out_instr_pc,
  output logic            out_instr_valid,
  input  logic            in_instr_taken,
  input  logic            in_redirect,
  input  logic [PC_W-1:0] in_redirect_pc,
  output logic [1:0]      out_fetch_state
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, tgt_q, tgt_d;
  logic            req_q;
  logic            push, pop, full, empty, no_room;
  logic [CW-1:0]   cnt;
  logic [PC_W+7:0] head;

  // A redirect kills both the returning byte and any consume of the (flushed) head.
  assign pop     = in_instr_taken & ~empty & ~in_redirect;
  assign push    = (state_q == F_REQ) & in_mem_ack & ~in_redirect;
  assign no_room = (full & ~pop) | (push & ~pop & (cnt == CW'(DEPTH - 1)));

  fetch_fifo #(.DEPTH(DEPTH), .W(PC_W + 8)) u_fifo (
    .clk_i   (in_clka),
    .rst_ni  (in_restart_n),
    .flush_i (in_redirect),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({pc_q, in_mem_data}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .cnt_o   (cnt)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    case (state_q)
      F_IDLE: state_d = F_REQ;
      F_REQ: begin
        if (in_mem_ack) begin
          pc_d = pc_q + 1'b1;
          if (no_room) state_d = F_FULL;
        end
      end
      F_FULL: if (pop) state_d = F_REQ;
      F_DROP: begin
        if (in_mem_ack) begin
          pc_d    = tgt_q;
          state_d = F_REQ;
        end
      end
      default: state_d = F_IDLE;
    endcase
    // An unacked request must finish on the bus with a stable address, so park the target.
    if (in_redirect) begin
      if ((state_q == F_REQ || state_q == F_DROP) && !in_mem_ack) begin
        pc_d    = pc_q;
        tgt_d   = in_redirect_pc;
        state_d = F_DROP;
      end else begin
        pc_d    = in_redirect_pc;
        state_d = F_REQ;
      end
    end
  end

  always_ff @(posedge in_clka) begin
    if (!in_restart_n) begin
      state_q <= F_IDLE;
      pc_q    <= PC_W'(RESET_PC);
      tgt_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      req_q   <= (state_d == F_REQ) || (state_d == F_DROP);
    end
  end

  assign out_mem_addr    = pc_q;
  assign out_mem_req     = req_q;
  assign out_instr_valid = ~empty;
  assign out_instr_pc    = head[PC_W+7:8];
  assign out_instruction = head[7:0];
  assign out_fetch_state = state_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a queue-based model of the fetch/redirect rules.
module tb_instr_fetch_unit;
  localparam int DEPTH = 2;

  logic       clk = 1'b0, rst_n = 1'b0, ack = 1'b0, taken = 1'b0, redir = 1'b0;
  logic [7:0] mdata = '0, rpc = '0;
  logic [7:0] out_mem_addr, out_instruction, out_instr_pc;
  logic       out_mem_req, out_instr_valid;
  logic [1:0] out_fetch_state;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .in_clka         (clk),
    .in_restart_n    (rst_n),
    .out_mem_addr    (out_mem_addr),
    .out_mem_req     (out_mem_req),
    .in_mem_ack      (ack),
    .in_mem_data     (mdata),
    .out_instruction (out_instruction),
    .out_instr_pc    (out_instr_pc),
    .out_instr_valid (out_instr_valid),
    .in_instr_taken  (taken),
    .in_redirect     (redir),
    .in_redirect_pc  (rpc),
    .out_fetch_state (out_fetch_state)
  );

  int n_chk = 0, n_err = 0;
  logic [7:0]  mem_img [256];
  logic [15:0] q [$];
  bit          m_idle, m_drop;
  logic [7:0]  m_pc, m_tgt;
  int          lat = -1, lat_min = 0, lat_max = 0, take_pct = 0, redir_pct = 0;
  bit          redir_now = 0;
  logic [7:0]  redir_tgt = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: compare, drive inputs, advance model, move to next negedge.
  task automatic cyc();
    logic [15:0] head;
    bit er;
    er   = !m_idle && (m_drop || q.size() < DEPTH);
    head = (q.size() != 0) ? q[0] : 16'h0;
    chk("req", out_mem_req, er);
    if (er) chk("addr", out_mem_addr, m_pc);
    chk("valid", out_instr_valid, q.size() != 0);
    chk("instr", out_instruction, head[7:0]);
    chk("ipc", out_instr_pc, head[15:8]);

    if (out_mem_req) begin
      if (lat < 0) lat = $urandom_range(lat_max, lat_min);
      ack = (lat == 0);
      lat = ack ? -1 : lat - 1;
    end else begin
      ack = 1'b0;
      lat = -1;
    end
    mdata     = mem_img[out_mem_addr];
    taken     = ($urandom_range(99) < take_pct);
    redir     = redir_now || ($urandom_range(99) < redir_pct);
    rpc       = redir_now ? redir_tgt : 8'($urandom);
    redir_now = 0;

    if (m_idle) begin
      m_idle = 0;
      if (redir) m_pc = rpc;
    end else if (redir) begin
      q.delete();
      if (er && !ack) begin
        m_drop = 1;
        m_tgt  = rpc;
      end else begin
        m_drop = 0;
        m_pc   = rpc;
      end
    end else begin
      if (taken && q.size() != 0) void'(q.pop_front());
      if (er && ack) begin
        if (m_drop) begin
          m_drop = 0;
          m_pc   = m_tgt;
        end else begin
          q.push_back({m_pc, mem_img[m_pc]});
          m_pc = m_pc + 8'd1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; ack = 1'b0; taken = 1'b0; redir = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    q.delete();
    m_idle = 1; m_drop = 0; m_pc = '0; m_tgt = '0; lat = -1;
    chk("rst_req", out_mem_req, 0);
    chk("rst_valid", out_instr_valid, 0);
    chk("rst_instr", out_instruction, 0);
    chk("rst_ipc", out_instr_pc, 0);
    chk("rst_state", out_fetch_state, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_img[i] = 8'($urandom);
    mem_img[0] = 8'hA0; mem_img[1] = 8'hB0; mem_img[2] = 8'h1F; mem_img[3] = 8'h0F;
    @(negedge clk);

    // 1: streaming with immediate ack and constant consume
    do_reset(2);
    lat_min = 0; lat_max = 0; take_pct = 100;
    repeat (12) cyc();

    // 2: backpressure fills the FIFO, one take resumes fetch at pc 2
    do_reset(1);
    take_pct = 0;
    repeat (3) cyc();
    chk("t2_state", out_fetch_state, 2);
    chk("t2_req", out_mem_req, 0);
    take_pct = 100; cyc(); take_pct = 0;
    chk("t2_req_resume", out_mem_req, 1);
    chk("t2_addr", out_mem_addr, 2);
    repeat (4) cyc();

    // 3: redirect while a slow request is outstanding
    do_reset(1);
    lat_min = 3; lat_max = 3; take_pct = 100;
    cyc(); cyc();
    redir_now = 1; redir_tgt = 8'h40; cyc();
    chk("t3_state", out_fetch_state, 3);
    chk("t3_addr_held", out_mem_addr, 0);
    for (int i = 0; i < 20; i++) begin
      if (out_instr_valid) break;
      cyc();
    end
    chk("t3_first_pc", out_instr_pc, 8'h40);

    // 4: redirect with a same-cycle take flushes a full FIFO
    do_reset(1);
    lat_min = 0; lat_max = 0; take_pct = 0;
    redir_now = 1; redir_tgt = 8'h05; cyc();
    repeat (2) cyc();
    chk("t4_head", out_instr_pc, 8'h05);
    chk("t4_state", out_fetch_state, 2);
    take_pct = 100; redir_now = 1; redir_tgt = 8'h10; cyc(); take_pct = 0;
    chk("t4_valid", out_instr_valid, 0);
    chk("t4_addr", out_mem_addr, 8'h10);
    take_pct = 100;
    repeat (4) cyc();

    // 5: PC wraps after the top address
    redir_now = 1; redir_tgt = 8'hFF; cyc();
    chk("t5_addr", out_mem_addr, 8'hFF);
    cyc();
    chk("t5_wrap", out_mem_addr, 8'h00);
    chk("t5_head", out_instr_pc, 8'hFF);

    // 6: reset while a request is outstanding and the FIFO holds data
    take_pct = 0;
    repeat (4) cyc();
    take_pct = 100; cyc(); take_pct = 0;
    lat_min = 3; lat_max = 3; cyc();
    chk("t6_pending", out_mem_req, 1);
    do_reset(1);
    lat_min = 0; lat_max = 0;
    cyc();
    chk("t6_addr", out_mem_addr, 0);
    chk("t6_req", out_mem_req, 1);
    repeat (3) cyc();

    // random mix of latency, consume and redirects
    do_reset(1);
    lat_min = 0; lat_max = 3; take_pct = 60; redir_pct = 6;
    repeat (3000) cyc();
    redir_pct = 0;
    do_reset(1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
